// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and PC helpers for fetch_stage
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A00000;
    localparam logic [31:0] PC_INC            = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DRAIN = 2'b10
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory REQ/RDY handshake bundle
interface fetch_stage_if;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic        IM_RDY;
    logic [31:0] IM_DATA;

    modport master (output IM_REQ, output IM_ADDR, input IM_RDY, input IM_DATA);
    modport slave  (input IM_REQ, input IM_ADDR, output IM_RDY, output IM_DATA);
endinterface

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register; flush wins over load
import fetch_pkg::*;

module if_id_register #(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD,
    input  logic        FLUSH,
    input  logic [31:0] INSTR_D,
    input  logic [31:0] NPC_D,
    input  logic        VALID_D,
    output logic [31:0] INSTR,
    output logic [31:0] NPC,
    output logic        VALID
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            INSTR <= NOP_INSTR;
            NPC   <= 32'd0;
            VALID <= 1'b0;
        end else if (FLUSH) begin
            INSTR <= NOP_INSTR;
            NPC   <= 32'd0;
            VALID <= 1'b0;
        end else if (LOAD) begin
            INSTR <= INSTR_D;
            NPC   <= NPC_D;
            VALID <= VALID_D;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with stall hold buffer and branch drain
// Optional stall counter enabled by FETCH_PERF_CNT_EN.
import fetch_pkg::*;

module fetch_stage #(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          PCout,
    output logic [31:0]          PCin,
    fetch_stage_if.master        im,
    input  logic                 LE,
    input  logic                 BR_TAKEN,
    input  logic [31:0]          BR_TARGET,
    output logic [31:0]          IFID_INSTR,
    output logic [31:0]          IFID_NPC,
    output logic                 IFID_VALID,
    output logic [31:0]          STALL_CNT
);

    fetch_state_t state, state_d;
    logic [31:0]  hold_instr, hold_npc, latched_addr;
    logic [31:0]  pc_inc, load_instr, load_npc, addr;
    logic         req, ifid_load, ifid_flush, hold_load, hold_clear;

    assign pc_inc = PCout + PC_INC;

    always_comb begin
        state_d    = state;
        PCin       = PCout;
        req        = 1'b0;
        addr       = PCout;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        load_instr = im.IM_DATA;
        load_npc   = pc_inc;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        case (state)
            FETCH: begin
                req = 1'b1;
                if (im.IM_RDY) begin
                    PCin = pc_inc;
                    if (LE) begin
                        ifid_load = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (LE) begin
                    ifid_flush = 1'b1;
                end
            end
            HOLD: begin
                if (LE) begin
                    ifid_load  = 1'b1;
                    load_instr = hold_instr;
                    load_npc   = hold_npc;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                req  = 1'b1;
                addr = latched_addr;
                if (LE) ifid_flush = 1'b1;
                if (im.IM_RDY) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // A taken branch kills whatever is in flight; an outstanding request is drained.
        if (BR_TAKEN) begin
            PCin       = word_align(BR_TARGET);
            ifid_flush = 1'b1;
            ifid_load  = 1'b0;
            hold_load  = 1'b0;
            hold_clear = 1'b1;
            state_d    = (state == HOLD || im.IM_RDY) ? FETCH : DRAIN;
        end

        if (RST) begin
            req  = 1'b0;
            PCin = PCout;
        end
    end

    assign im.IM_REQ  = req;
    assign im.IM_ADDR = addr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= FETCH;
            hold_instr   <= 32'd0;
            hold_npc     <= 32'd0;
            latched_addr <= 32'd0;
        end else begin
            state <= state_d;
            if (state == FETCH) latched_addr <= PCout;
            if (hold_clear) begin
                hold_instr <= 32'd0;
                hold_npc   <= 32'd0;
            end else if (hold_load) begin
                hold_instr <= im.IM_DATA;
                hold_npc   <= pc_inc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_q <= 32'd0;
        else if (state != FETCH || (req && !im.IM_RDY))
            stall_q <= stall_q + 32'd1;
    end
    assign STALL_CNT = stall_q;
`else
    assign STALL_CNT = 32'd0;
`endif

    if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .CLK     (CLK),
        .RST     (RST),
        .LOAD    (ifid_load),
        .FLUSH   (ifid_flush),
        .INSTR_D (load_instr),
        .NPC_D   (load_npc),
        .VALID_D (1'b1),
        .INSTR   (IFID_INSTR),
        .NPC     (IFID_NPC),
        .VALID   (IFID_VALID)
    );

endmodule
